dual_button_debounce: RTL
=========================

Name: dual_button_debounce

Overview:
- Upstream conditioning stage for the two push-button pulse/toggle register.
- Takes two raw, asynchronous, bouncing button inputs and synchronizes each into clk.
- Debounces each input independently and drives clean level signals.
- Its outputs drive the toggle register's s1/s2 inputs directly, so each physical press yields exactly one clean rising edge downstream.

Parameters:
- DEBOUNCE_CYCLES, 50000, number of consecutive stable synchronized samples required to accept a level change; legal range 2 to 2^CNT_W.
- CNT_W, 16, width of each per-channel stability counter.
- ACTIVE_LOW, 0, 1 = raw buttons are pressed-low; raw inputs are inverted after synchronization so outputs are always active-high.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn1_raw  input  1  raw asynchronous button 1.
- btn2_raw  input  1  raw asynchronous button 2.
- s1  output  1  debounced active-high level, channel 1.
- s2  output  1  debounced active-high level, channel 2.
- busy  output  1  high while either channel is in a WAIT state.

Behaviour:
- Clocking and reset:
  - Reset rst is synchronous, active-high; clock is clk; all state updates on posedge clk.
- Synchronizer:
  - Each channel uses a 2-flop synchronizer on the raw input.
  - Synchronizer flops reset to the raw inactive level: 0 if ACTIVE_LOW=0, 1 if ACTIVE_LOW=1.
  - The synchronized value is inverted when ACTIVE_LOW=1, giving "sync", which is 1 when pressed.
  - No false press is seen after reset.
- Per-channel FSM, four states:
  - IDLE_LO: output 0.
    - sync=1 -> WAIT_HI, counter cleared to 0.
  - WAIT_HI: output 0.
    - sync=0 -> IDLE_LO, counter cleared.
    - sync=1 and counter==DEBOUNCE_CYCLES-1 -> IDLE_HI, output set to 1.
    - Otherwise counter +1.
  - IDLE_HI: output 1.
    - sync=0 -> WAIT_LO, counter cleared.
  - WAIT_LO: output 1.
    - sync=1 -> IDLE_HI, counter cleared.
    - sync=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE_LO, output set to 0.
    - Otherwise counter +1.
- Outputs s1/s2 are registered, driven from the FSM state; there are no combinational paths from raw inputs.
- Latency:
  - A clean raw transition captured at edge k appears on the output after edge k+DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges counting the capture edge.
  - This applies identically to press and release.
- Glitch rejection:
  - Any sync deviation while in a WAIT state returns the channel to its IDLE state and restarts qualification from zero.
  - The output never changes on a glitch whose synchronized width is at most DEBOUNCE_CYCLES.
- Counter:
  - Unsigned CNT_W bits; it never exceeds DEBOUNCE_CYCLES-1, so no wrap-around.
- Channel independence:
  - Channels are fully independent; simultaneous presses, releases or bounces on both channels are handled in parallel with no interaction.
  - Both outputs may change on the same edge.
- busy: registered OR of (channel in WAIT_HI or WAIT_LO), reset 0.
- Reset:
  - Reset values: FSMs IDLE_LO, counters 0, s1=0, s2=0, busy=0.
  - Reset asserted mid-qualification or while an output is high forces all reset values on the next edge, even if the button is still held.
  - A held button after reset release is re-qualified, producing one clean rising edge after the full latency.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=0 unless stated):
- Reset then idle: rst high 3 cycles, inputs 0 -> s1=s2=busy=0 throughout and for 20 cycles after release.
- Clean press: btn1_raw 0->1 before edge 1, held -> s1 rises at edge 7 (N+3), busy high during WAIT_HI, s2 stays 0; release -> s1 falls 7 edges after the release capture.
- Bounce rejection: btn1_raw pulses high for 3 cycles, low 2, high 2, low -> s1 stays 0; then held high 10 cycles -> s1 rises exactly 7 edges after the final stable rise.
- Simultaneous channels: btn1_raw and btn2_raw rise on the same cycle -> s1 and s2 rise on the same edge 7; btn2 glitch during btn1 qualification does not delay s1.
- Reset mid-operation: btn1 held, s1=1, assert rst one cycle -> s1=0 next edge; after release, with btn1 still held -> s1 re-rises 7 edges later.
- ACTIVE_LOW=1: raw idles at 1, reset -> s1=0; raw 1->0 -> s1 rises at edge 7; raw 0->1 -> s1 falls at edge 7.

Source files
------------

// File: rtl/dual_button_debounce.sv
// Two-channel button conditioner. Each raw button input is synchronized into
// clk, optionally inverted to active-high, and debounced by a four-state FSM
// with a stability counter. The outputs are clean registered levels that feed
// the pulse/toggle register's s1/s2 inputs.

module dual_button_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic waiting
);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_ff;
  logic             sync;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer. It resets to the idle raw level so that no press
  // is seen after reset.
  always_ff @(posedge clk) begin
    if (rst) sync_ff <= {2{ACTIVE_LOW}};
    else     sync_ff <= {sync_ff[0], raw};
  end

  assign sync = sync_ff[1] ^ ACTIVE_LOW;

  // Debounce FSM. Any deviation in a WAIT state returns the channel to its
  // idle state, so qualification always restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE_LO;
      cnt     <= '0;
      level   <= 1'b0;
      waiting <= 1'b0;
    end else begin
      case (state)
        IDLE_LO: if (sync) begin
          state   <= WAIT_HI;
          cnt     <= '0;
          waiting <= 1'b1;
        end
        WAIT_HI: begin
          if (!sync) begin
            state   <= IDLE_LO;
            cnt     <= '0;
            waiting <= 1'b0;
          end else if (cnt == LAST) begin
            state   <= IDLE_HI;
            cnt     <= '0;
            level   <= 1'b1;
            waiting <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HI: if (!sync) begin
          state   <= WAIT_LO;
          cnt     <= '0;
          waiting <= 1'b1;
        end
        WAIT_LO: begin
          if (sync) begin
            state   <= IDLE_HI;
            cnt     <= '0;
            waiting <= 1'b0;
          end else if (cnt == LAST) begin
            state   <= IDLE_LO;
            cnt     <= '0;
            level   <= 1'b0;
            waiting <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE_LO;
          cnt     <= '0;
          level   <= 1'b0;
          waiting <= 1'b0;
        end
      endcase
    end
  end

endmodule

module dual_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic s1,
  output logic s2,
  output logic busy
);

  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] level;
  logic [NUM_LANES-1:0] waiting;

  assign raw = {btn2_raw, btn1_raw};

  // The channels are fully independent and share nothing but clock and reset.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_ch
    dual_button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw[g]),
      .level  (level[g]),
      .waiting(waiting[g])
    );
  end

  assign s1 = level[0];
  assign s2 = level[1];
  // busy is an OR of per-channel flops that track the WAIT states, so it
  // carries no combinational path from the raw inputs.
  assign busy = |waiting;

endmodule
